// File: rtl/decoder3to8_hold.sv
// decoder3to8_hold: accepts a 3-bit code and drives its one-hot decode for HOLD cycles.
// Latency: out8/out_valid update on the accepting edge and are visible the following cycle.
// Backpressure: in_ready is low for the whole hold window, so codes offered then are dropped.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous, active-high reset
//   in3       - binary code to decode
//   in_valid  - in3 carries a code this cycle
//   in_ready  - block will accept a code this cycle (high exactly when idle)
//   out8      - registered one-hot decode, all-zero when out_valid is low
//   out_valid - out8 holds a valid one-hot word
//   code_cnt  - 8-bit wrapping count of accepted codes
module decoder3to8_hold #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in3,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out8,
  output logic       out_valid,
  output logic [7:0] code_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // The counter is loaded with HOLD-1 so the word is driven while it counts
  // HOLD-1 .. 0, and the edge that finds it at zero clears the outputs.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t     state_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] out8_q;
  logic       out_valid_q;
  logic [7:0] code_cnt_q;

  logic       accept;
  logic [7:0] decode_d;
  logic [7:0] code_cnt_d;
  logic [7:0] hold_cnt_d;

  // Reset forces S_IDLE asynchronously, so in_ready reads 1 throughout reset.
  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_ready && in_valid;

  assign decode_d   = 8'd1 << in3;
  assign code_cnt_d = code_cnt_q + 8'd1;  // wraps FF -> 00 by width
  assign hold_cnt_d = hold_cnt_q - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= 8'd0;
      out8_q      <= 8'h00;
      out_valid_q <= 1'b0;
      code_cnt_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            out8_q      <= decode_d;
            out_valid_q <= 1'b1;
            hold_cnt_q  <= HOLD_LOAD;
            code_cnt_q  <= code_cnt_d;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Inputs are ignored here, including on the final hold cycle,
          // which enforces a minimum accept spacing of HOLD+1 cycles.
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_q <= hold_cnt_d;
          end else begin
            out8_q      <= 8'h00;
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out8_q      <= 8'h00;
          out_valid_q <= 1'b0;
          hold_cnt_q  <= 8'd0;
        end
      endcase
    end
  end

  assign out8      = out8_q;
  assign out_valid = out_valid_q;
  assign code_cnt  = code_cnt_q;

endmodule

// File: tb/tb_decoder3to8_hold.sv
module tb_decoder3to8_hold;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // HOLD=4 instance
  logic [2:0] in3;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out8;
  logic       out_valid;
  logic [7:0] code_cnt;

  // HOLD=1 instance
  logic [2:0] in3_1;
  logic       in_valid_1;
  logic       in_ready_1;
  logic [7:0] out8_1;
  logic       out_valid_1;
  logic [7:0] code_cnt_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder3to8_hold #(.HOLD(HOLD)) u_dut (
    .clk(clk), .rst(rst), .in3(in3), .in_valid(in_valid), .in_ready(in_ready),
    .out8(out8), .out_valid(out_valid), .code_cnt(code_cnt)
  );

  decoder3to8_hold #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .in3(in3_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .out8(out8_1), .out_valid(out_valid_1), .code_cnt(code_cnt_1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "cycles left to show the word" plus the word's code.
  // A code is taken whenever nothing is being shown; each edge burns one cycle.
  int       rem0 = 0, rem1 = 0;
  int       cnt0 = 0, cnt1 = 0;
  logic [2:0] code0 = 3'd0, code1 = 3'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem0 <= 0; cnt0 <= 0;
      rem1 <= 0; cnt1 <= 0;
    end else begin
      if (rem0 == 0) begin
        if (in_valid) begin
          code0 <= in3; rem0 <= HOLD; cnt0 <= (cnt0 + 1) % 256;
        end
      end else begin
        rem0 <= rem0 - 1;
      end
      if (rem1 == 0) begin
        if (in_valid_1) begin
          code1 <= in3_1; rem1 <= 1; cnt1 <= (cnt1 + 1) % 256;
        end
      end else begin
        rem1 <= rem1 - 1;
      end
    end
  end

  // Per-cycle comparison against the model plus the one-hot legality rule.
  always @(negedge clk) begin
    logic [7:0] e8;
    e8 = (rem0 > 0) ? (8'd1 << code0) : 8'd0;
    chk("m_out8", out8, e8);
    chk("m_out_valid", out_valid, rem0 > 0);
    chk("m_in_ready", in_ready, rem0 == 0);
    chk("m_code_cnt", code_cnt, cnt0[7:0]);
    chk("legal_out8", out_valid ? $onehot(out8) : (out8 == 8'h00), 1);
    e8 = (rem1 > 0) ? (8'd1 << code1) : 8'd0;
    chk("m1_out8", out8_1, e8);
    chk("m1_out_valid", out_valid_1, rem1 > 0);
    chk("m1_in_ready", in_ready_1, rem1 == 0);
    chk("m1_code_cnt", code_cnt_1, cnt1[7:0]);
    chk("legal_out8_1", out_valid_1 ? $onehot(out8_1) : (out8_1 == 8'h00), 1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic accept(input logic [2:0] c);
    wait_ready();
    in_valid = 1'b1;
    in3      = c;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] lit [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    int n;
    in_valid   = 1'b0;
    in3        = 3'd0;
    in_valid_1 = 1'b1;
    in3_1      = 3'd5;
    #1 rst = 1'b1;
    #2;
    chk("rst_out8", out8, 8'h00);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code_cnt", code_cnt, 8'h00);
    chk("rst_in_ready", in_ready, 1);

    // No accept while reset is held, even with in_valid high.
    in_valid = 1'b1;
    in3      = 3'd3;
    step();
    step();
    chk("rst_no_accept_cnt", code_cnt, 8'h00);
    chk("rst_no_accept_vld", out_valid, 0);

    // First edge after release accepts.
    rst = 1'b0;
    in3 = 3'd6;
    step();
    in_valid = 1'b0;
    chk("first_acc_vld", out_valid, 1);
    chk("first_acc_out8", out8, 8'h40);
    chk("first_acc_cnt", code_cnt, 8'h01);

    // All eight codes, each held exactly HOLD cycles.
    wait_ready();
    pulse_rst();
    for (int i = 0; i < 8; i++) begin
      accept(3'(i));
      chk("dec_out8", out8, lit[i]);
      n = 0;
      while (out_valid && n < 20) begin
        n++;
        step();
      end
      chk("dec_hold_len", n, 4);
    end
    chk("dec_code_cnt", code_cnt, 8'h08);

    // in_valid held with in3 changing every cycle: 50 edges -> 10 accepts.
    // The HOLD=1 instance alternates 20/00 over the same edges.
    pulse_rst();
    in_valid = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      in3 = 3'($urandom);
      step();
      if (k <= 8) begin
        chk("hold1_out8", out8_1, (k % 2) ? 8'h20 : 8'h00);
        chk("hold1_vld", out_valid_1, k % 2);
      end
    end
    in_valid = 1'b0;
    chk("stream_accepts", code_cnt, 8'd10);

    // Reset two cycles into a hold of code 7.
    wait_ready();
    accept(3'd7);
    step();
    step();
    chk("pre_abort_out8", out8, 8'h80);
    #1 rst = 1'b1;
    #1;
    chk("abort_out8", out8, 8'h00);
    chk("abort_vld", out_valid, 0);
    chk("abort_cnt", code_cnt, 8'h00);
    chk("abort_ready", in_ready, 1);
    rst = 1'b0;

    // 256 accepts wrap the counter; the 257th reads 1.
    step();
    pulse_rst();
    in_valid = 1'b1;
    for (int k = 0; k < 256 * 5; k++) begin
      in3 = 3'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_256", code_cnt, 8'h00);
    accept(3'($urandom));
    chk("wrap_257", code_cnt, 8'h01);

    // Random traffic on both instances with occasional async resets.
    for (int k = 0; k < 400; k++) begin
      in_valid   = 1'($urandom);
      in3        = 3'($urandom);
      in_valid_1 = 1'($urandom);
      in3_1      = 3'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder3to8_hold.md
DECODER3TO8_HOLD -- requirements
Module: decoder3to8_hold

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, meaning the number of cycles each decoded one-hot word is driven (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in3, input, 3, the binary code to decode.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in3 carries a code this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a code this cycle.
REQ-007 The block SHALL have port out8, output, 8, the registered one-hot decode of the accepted code.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out8 holds a valid one-hot word.
REQ-009 The block SHALL have port code_cnt, output, 8, the count of accepted codes.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-011 in_ready SHALL be combinationally 1 in IDLE and 0 in HOLD, independent of in_valid.
REQ-012 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 On accept: out8 <= 8'b1 << in3; out_valid <= 1; hold counter <= HOLD-1; FSM -> HOLD; code_cnt <= code_cnt+1.
REQ-014 Latency: out8/out_valid SHALL update on the same edge that accepts; visible from the cycle after in_valid is sampled.
REQ-015 In HOLD, out8 and out_valid SHALL remain constant; hold counter decrements by 1 per edge while nonzero.
REQ-016 In HOLD with hold counter = 0, the next edge SHALL set out8 <= 8'h00, out_valid <= 0, FSM -> IDLE.
REQ-017 out_valid SHALL therefore be high for exactly HOLD consecutive cycles per accepted code.
REQ-018 With HOLD=1, the counter loads 0 and the word SHALL be driven exactly one cycle.
REQ-019 in_valid and in3 SHALL be ignored in HOLD, including the last HOLD cycle; no back-to-back accepts; minimum accept spacing is HOLD+1 cycles.
REQ-020 in_valid=1 held continuously SHALL yield one accept per HOLD+1 cycles, each sampling in3 at its accept edge.
REQ-021 out8 SHALL be either all-zero (out_valid=0) or exactly one bit set (out_valid=1); no other value is legal.
REQ-022 code_cnt SHALL be an 8-bit wrapping counter: 8'hFF + 1 -> 8'h00, no saturation flag.
REQ-023 Hold counter width SHALL be 8 bits; HOLD outside 1..255 is unsupported.

Reset
REQ-024 On rst=1, immediately and without waiting for clk: FSM=IDLE, out8=8'h00, out_valid=0, code_cnt=8'h00, hold counter=0.
REQ-025 in_ready SHALL read 1 while rst=1 is asserted; no accept SHALL occur on any edge while rst=1.
REQ-026 rst asserted mid-HOLD SHALL abort the hold: outputs clear asynchronously, counter is not incremented further.
REQ-027 First accept after rst deasserts SHALL be possible on the first rising edge with rst=0.

Verification (HOLD=4 unless stated)
REQ-028 Reset, then in3=3'd0..3'd7 each presented when in_ready=1 -> out8 = 8'h01,02,04,08,10,20,40,80 respectively, each for exactly 4 cycles, code_cnt ends at 8'h08.
REQ-029 in_valid held 1 with in3 changing every cycle -> accept every 5 cycles, out8 reflects in3 sampled at the accept edge only; in_ready low 4 cycles after each accept.
REQ-030 HOLD=1 build, in_valid held 1, in3=3'd5 -> out8 alternates 8'h20 / 8'h00 each cycle, out_valid toggles 1/0.
REQ-031 Assert rst two cycles into a hold of in3=3'd7 -> out8=8'h00, out_valid=0, code_cnt=8'h00 before the next clk edge; in_ready=1.
REQ-032 256 accepts from reset -> code_cnt returns to 8'h00; 257th accept -> 8'h01.
REQ-033 Every cycle of every test, a checker SHALL confirm out8 is 8'h00 when out_valid=0 and one-hot when out_valid=1.
